// File: rtl/aes_128_key_mem_if.sv
// Consumer-facing bus of the AES-128 key memory: expansion start, cipher key,
// round-key read index and the returned round key with its ready flag.
interface aes_128_key_mem_if;
    logic         init;
    logic [127:0] key;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;

    modport master (
        output init,
        output key,
        output round,
        input  round_key,
        input  ready
    );

    modport slave (
        input  init,
        input  key,
        input  round,
        output round_key,
        output ready
    );
endinterface

// File: rtl/aes_128_key_mem.sv
// AES-128 key expansion and round-key store. One round key is produced per
// cycle through a single shared 32-bit S-box and written into an 11-entry
// register memory. Reads are purely combinational on the requested round.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | key memory stable, ready=1, waiting for init
// GENERATE | writing round keys 1..10, one per cycle, ready=0
module aes_128_key_mem (
    input  logic                     clk,
    input  logic                     reset_n,
    aes_128_key_mem_if.slave         kbus
);

    localparam int unsigned NUM_KEYS = 11;
    localparam logic [3:0]  LAST_ROUND = 4'd10;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic {
        IDLE     = 1'b0,
        GENERATE = 1'b1
    } state_t;

    state_t       state_reg;
    state_t       state_next;
    logic [127:0] key_mem [NUM_KEYS];
    logic [127:0] prev_key_reg;
    logic [7:0]   rcon_reg;
    logic [3:0]   round_ctr_reg;

    logic         init_accept;
    logic         gen_step;
    logic         gen_last;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_w;
    logic [31:0]  t_w;
    logic [31:0]  k0, k1, k2, k3;
    logic [127:0] new_key;
    logic [7:0]   rcon_next;
    logic [127:0] round_key_mux;

    // Next round key from the previous one via the single shared S-box.
    always_comb begin
        w0        = prev_key_reg[127:96];
        w1        = prev_key_reg[95:64];
        w2        = prev_key_reg[63:32];
        w3        = prev_key_reg[31:0];
        rot_w3    = {w3[23:0], w3[31:24]};
        sub_w     = {SBOX[rot_w3[31:24]], SBOX[rot_w3[23:16]],
                     SBOX[rot_w3[15:8]],  SBOX[rot_w3[7:0]]};
        t_w       = sub_w ^ {rcon_reg, 24'h000000};
        k0        = w0 ^ t_w;
        k1        = w1 ^ k0;
        k2        = w2 ^ k1;
        k3        = w3 ^ k2;
        new_key   = {k0, k1, k2, k3};
        rcon_next = {rcon_reg[6:0], 1'b0} ^ (8'h1b & {8{rcon_reg[7]}});
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath strobes; init is only honoured from IDLE.
    always_comb begin
        state_next  = state_reg;
        init_accept = 1'b0;
        gen_step    = 1'b0;
        gen_last    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (kbus.init) begin
                    init_accept = 1'b1;
                    state_next  = GENERATE;
                end
            end
            GENERATE: begin
                gen_step = 1'b1;
                if (round_ctr_reg == LAST_ROUND) begin
                    gen_last   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Key memory, previous key, rcon and round counter updates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_mem[i] <= '0;
            end
            prev_key_reg  <= '0;
            rcon_reg      <= '0;
            round_ctr_reg <= '0;
        end else if (init_accept) begin
            key_mem[0]    <= kbus.key;
            prev_key_reg  <= kbus.key;
            rcon_reg      <= 8'h01;
            round_ctr_reg <= 4'd1;
        end else if (gen_step) begin
            for (int i = 1; i < NUM_KEYS; i++) begin
                if (round_ctr_reg == 4'(i)) begin
                    key_mem[i] <= new_key;
                end
            end
            prev_key_reg  <= new_key;
            rcon_reg      <= rcon_next;
            round_ctr_reg <= gen_last ? 4'd0 : round_ctr_reg + 4'd1;
        end
    end

    // Zero-latency round-key read; indices beyond 10 read as zero.
    always_comb begin
        round_key_mux = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (kbus.round == 4'(i)) begin
                round_key_mux = key_mem[i];
            end
        end
    end

    assign kbus.round_key = round_key_mux;
    assign kbus.ready     = (state_reg == IDLE);

endmodule

// File: tb/tb_aes_128_key_mem.sv
// Scoreboard bench for aes_128_key_mem: stimulus pushes the expected
// round key and ready level, a negedge monitor pops and compares.
module tb_aes_128_key_mem;

    logic clk;
    logic reset_n;

    aes_128_key_mem_if kbus ();

    aes_128_key_mem dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kbus    (kbus)
    );

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
        logic         rdy;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // FIPS-197 A.1 round keys.
    logic [127:0] A1 [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    // FIPS-197 C.1 round keys.
    logic [127:0] C1 [11] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per cycle, compared away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (kbus.round_key === e.key) n_pass++;
            else $display("FAIL round_key[%0d] got %h expected %h", e.rnd, kbus.round_key, e.key);
            n_checks++;
            if (kbus.ready === e.rdy) n_pass++;
            else $display("FAIL ready@round%0d got %b expected %b", e.rnd, kbus.ready, e.rdy);
        end
    end

    // Drive a read index and queue its expectation; advances one cycle.
    task automatic check_round(input logic [3:0] r, input logic [127:0] k, input logic rdy);
        exp_t e;
        kbus.round = r;
        e.rnd = r;
        e.key = k;
        e.rdy = rdy;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s got %0d expected %0d", name, act, expv);
    endtask

    // Pulse init for one edge, then scramble key to show it is not re-sampled.
    task automatic do_init(input logic [127:0] k);
        kbus.key  = k;
        kbus.init = 1'b1;
        @(posedge clk);
        #1;
        kbus.init = 1'b0;
        kbus.key  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Count remaining cycles with ready low (bounded).
    task automatic wait_ready(input string name, input int exp_low);
        int cnt = 0;
        while (kbus.ready !== 1'b1 && cnt < 50) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        check_val(name, cnt, exp_low);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        kbus.init  = 1'b0;
        kbus.key   = '0;
        kbus.round = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state: every index reads zero, ready high.
        for (int r = 0; r < 16; r++) check_round(4'(r), '0, 1'b1);

        // A.1 expansion.
        do_init(A1[0]);
        wait_ready("a1_ready_low_cycles", 10);
        for (int r = 0; r < 11; r++) check_round(4'(r), A1[r], 1'b1);
        check_round(4'd11, '0, 1'b1);
        check_round(4'd15, '0, 1'b1);

        // C.1 re-key: reads mid-expansion see new key 0 and stale key 5.
        do_init(C1[0]);
        check_round(4'd0, C1[0], 1'b0);
        check_round(4'd5, A1[5], 1'b0);
        check_round(4'd12, '0, 1'b0);
        wait_ready("c1_ready_low_cycles", 7);
        for (int r = 10; r >= 0; r--) check_round(4'(r), C1[r], 1'b1);

        // Busy init with key 0 at T+4 is ignored.
        do_init(A1[0]);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        kbus.key  = '0;
        kbus.init = 1'b1;
        @(posedge clk);
        #1;
        kbus.init = 1'b0;
        wait_ready("busy_ready_low_cycles", 6);
        for (int r = 0; r < 11; r++) check_round(4'(r), A1[r], 1'b1);

        // Reset asserted mid-expansion clears everything at once.
        do_init(C1[0]);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        check_round(4'd0, '0, 1'b1);
        check_round(4'd1, '0, 1'b1);
        check_round(4'd4, '0, 1'b1);
        check_round(4'd10, '0, 1'b1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        do_init(C1[0]);
        wait_ready("post_reset_ready_low_cycles", 10);
        for (int r = 0; r < 11; r++) check_round(4'(r), C1[r], 1'b1);

        repeat (2) @(posedge clk);
        #1;
        check_val("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
